ysyx_23060203_wbu: RTL

//  Write-back unit between the execute stage and the register file. Takes one

---
 rtl/ysyx_23060203_wbu.sv | 148 ++++++++++++++
 1 files changed

// File: rtl/ysyx_23060203_wbu.sv
// Write-back unit: retires one instruction at a time from the execute stage.
// ALU results are written straight back; loads go through a single memory
// read, then the selected byte/half/word is extended and written back.
module ysyx_23060203_wbu #(
    parameter int unsigned NR_REG = 16
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [4:0]  in_rd,
    input  logic [31:0] in_result,
    input  logic        in_is_load,
    input  logic [2:0]  in_funct3,
    output logic        mem_req_valid,
    input  logic        mem_req_ready,
    output logic [31:0] mem_req_addr,
    input  logic        mem_resp_valid,
    input  logic [31:0] mem_resp_data,
    input  logic        mem_resp_err,
    output logic        rf_wen,
    output logic [4:0]  rf_waddr,
    output logic [31:0] rf_wdata,
    output logic        commit,
    output logic        err
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_WAIT,
        S_WRITE
    } state_t;

    state_t      state;
    logic [4:0]  rd_q;
    logic [31:0] addr_q;
    logic [2:0]  funct3_q;
    logic [31:0] data_q;

    // Load width/sign legality together with natural alignment.
    function automatic logic load_legal(input logic [2:0] f3, input logic [1:0] a);
        logic ok;
        case (f3)
            3'b000, 3'b100: ok = 1'b1;
            3'b001, 3'b101: ok = ~a[0];
            3'b010:         ok = (a == 2'b00);
            default:        ok = 1'b0;
        endcase
        return ok;
    endfunction

    // Pick the addressed byte/half out of the read word and extend it.
    function automatic logic [31:0] extract(input logic [2:0]  f3,
                                            input logic [1:0]  a,
                                            input logic [31:0] word);
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] r;
        b = word[{a, 3'b000} +: 8];
        h = word[{a[1], 4'b0000} +: 16];
        case (f3)
            3'b000:  r = {{24{b[7]}}, b};
            3'b100:  r = {24'b0, b};
            3'b001:  r = {{16{h[15]}}, h};
            3'b101:  r = {16'b0, h};
            default: r = word;
        endcase
        return r;
    endfunction

    // x0 is hardwired and registers beyond NR_REG do not exist.
    function automatic logic wen_ok(input logic [4:0] rd);
        return (rd != 5'd0) && (32'(rd) < NR_REG);
    endfunction

    // The cycle right after an err pulse is not offered to the EXU, so an
    // immediately repeated illegal load cannot stretch err to two cycles.
    assign in_ready     = (state == S_IDLE) && !err;
    assign mem_req_addr = {addr_q[31:2], 2'b00};
    assign rf_waddr     = rd_q;
    assign rf_wdata     = data_q;

    // Single FSM: all outputs are registered and set on the transition.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state         <= S_IDLE;
            rd_q          <= '0;
            addr_q        <= '0;
            funct3_q      <= '0;
            data_q        <= '0;
            mem_req_valid <= 1'b0;
            rf_wen        <= 1'b0;
            commit        <= 1'b0;
            err           <= 1'b0;
        end else begin
            rf_wen <= 1'b0;
            commit <= 1'b0;
            err    <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (in_valid && in_ready) begin
                        rd_q     <= in_rd;
                        addr_q   <= in_result;
                        funct3_q <= in_funct3;
                        if (!in_is_load) begin
                            data_q <= in_result;
                            rf_wen <= wen_ok(in_rd);
                            commit <= 1'b1;
                            state  <= S_WRITE;
                        end else if (load_legal(in_funct3, in_result[1:0])) begin
                            mem_req_valid <= 1'b1;
                            state         <= S_REQ;
                        end else begin
                            err <= 1'b1;
                        end
                    end
                end
                S_REQ: begin
                    if (mem_req_ready) begin
                        mem_req_valid <= 1'b0;
                        state         <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (mem_resp_valid) begin
                        if (mem_resp_err) begin
                            err   <= 1'b1;
                            state <= S_IDLE;
                        end else begin
                            data_q <= extract(funct3_q, addr_q[1:0], mem_resp_data);
                            rf_wen <= wen_ok(rd_q);
                            commit <= 1'b1;
                            state  <= S_WRITE;
                        end
                    end
                end
                S_WRITE: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
